serial_adder_ctrl: RTL and testbench

Bit-serial addition controller for the single-bit full-adder cell. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through one `fa` instance, one bit per clock. It holds the carry in a flip-flop between bits and assembles the sum in a shift register. It sits between an operand producer and a result consumer wherever area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder; operands are fed LSB-first through one full-adder cell.
// Latency : out_valid_o rises WIDTH edges after the accept edge; one operation per WIDTH+2 cycles at best.
// Backpr. : the result is held in DONE for as long as out_ready_i stays low; in_ready_o is high only in IDLE.
// Option  : define SERIAL_ADDER_SUB_EN to add the sub_i port (A - B by inverting B and forcing carry-in).

// Single-bit full-adder cell.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic Cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign Cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

  // Operand conditioning at load: subtraction is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub_i ? ~b_i : b_i;
  assign cin_load = sub_i | cin_i;
`else
  assign b_load   = b_i;
  assign cin_load = cin_i;
`endif

  fa u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .Cout_o (fa_c)
  );

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = vld_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so the first bit ends up in bit 0.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB while the last bit is processed.
          cnt_d   = '0;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          vld_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed vectors push expected results,
// a monitor pops and compares on each rising out_valid_o.
// Also covers back-pressure hold, mid-operation reset and (optionally) subtraction.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .cin_i       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i       (sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Issue one operation from a negedge; returns at a negedge after the result
  // is taken (or while it is held when out_ready is low).
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    e.sum  = esum;
    e.cout = ecout;
    e.ovf  = eovf;
    e.due  = cyc + 1 + W;
    e.name = name;
    sb.push_back(e);
    a = ta;
    b = tb_v;
    cin = tcin;
    sub = tsub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    if (out_ready) @(negedge clk);
  endtask

  // Monitor: compares each new result against the scoreboard and checks it holds.
  initial begin : monitor
    logic         prev_vld;
    int           busy_cnt;
    logic [W-1:0] hs;
    logic         hc;
    logic         ho;
    exp_t         e;
    prev_vld = 1'b0;
    busy_cnt = 0;
    hs = '0;
    hc = 1'b0;
    ho = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (out_valid && !prev_vld) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_sum"}, 32'(sum), 32'(e.sum));
            check({e.name, "_cout"}, 32'(cout), 32'(e.cout));
            check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
            check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
          end
          busy_cnt = 0;
          hs = sum;
          hc = cout;
          ho = ovf;
        end else if (out_valid && prev_vld) begin
          check("hold_stable_sum", 32'(sum), 32'(hs));
          check("hold_stable_cout", 32'(cout), 32'(hc));
          check("hold_stable_ovf", 32'(ovf), 32'(ho));
        end
        prev_vld = out_valid;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_00_00_c1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("add_aa_55_c1", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure: result held for 5 cycles, new operands ignored.
    out_ready = 1'b0;
    run_op("hold_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready_low", 32'(in_ready), 32'd0);
      check("hold_out_valid_high", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("no_accept_in_done_busy", 32'(busy), 32'd0);
    check("idle_sum_kept", 32'(sum), 32'h46);
    out_ready = 1'b1;

    // Reset after bit 3 of 0x7F + 0x01: partial result discarded.
    a = 8'h7F;
    b = 8'h01;
    cin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    check("midrun_rst_cout", 32'(cout), 32'd0);
    check("midrun_rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("after_rst_no_valid", 32'(out_valid), 32'd0);
    run_op("after_rst_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
